// File: rtl/uart_echo_buffer.sv
// Buffered UART echo: received bytes are queued in a FIFO and replayed on the
// TX valid/ready handshake through a registered output stage.
module uart_echo_buffer #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_FIFO_DEPTH = 16,
    parameter int P_CASE_SWAP  = 0,
    localparam int LP_AW = $clog2(P_FIFO_DEPTH),
    localparam int LP_CW = LP_AW + 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [P_DATA_WIDTH-1:0] i_user_rx_data,
    input  logic                    i_user_rx_valid,
    output logic [P_DATA_WIDTH-1:0] o_user_tx_data,
    output logic                    o_user_tx_valid,
    input  logic                    i_user_tx_ready,
    output logic [LP_CW-1:0]        o_fifo_count,
    output logic                    o_overflow,
    output logic [15:0]             o_drop_cnt
);

    // TX handshake: a byte moves at an edge where o_user_tx_valid and
    // i_user_tx_ready are both high; until then data/valid hold stable.

    logic [P_DATA_WIDTH-1:0] mem_q [P_FIFO_DEPTH];
    logic [LP_AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [LP_AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LP_CW-1:0]        count_q, count_d;
    logic [P_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    overflow_q, overflow_d;
    logic [15:0]             drop_cnt_q, drop_cnt_d;

    logic                    fifo_full, fifo_empty;
    logic                    wr_en, drop, xfer, load, rd_en;
    logic [P_DATA_WIDTH-1:0] rd_data, load_data;

    function automatic logic [P_DATA_WIDTH-1:0] swap_case(input logic [P_DATA_WIDTH-1:0] b);
        logic is_upper;
        logic is_lower;
        is_upper = (b >= P_DATA_WIDTH'(8'h41)) && (b <= P_DATA_WIDTH'(8'h5A));
        is_lower = (b >= P_DATA_WIDTH'(8'h61)) && (b <= P_DATA_WIDTH'(8'h7A));
        return (is_upper || is_lower) ? (b ^ P_DATA_WIDTH'(8'h20)) : b;
    endfunction

    assign fifo_full  = (count_q == LP_CW'(P_FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign rd_data    = mem_q[rd_ptr_q];
    assign load_data  = (P_CASE_SWAP != 0) ? swap_case(rd_data) : rd_data;

    always_comb begin
        wr_en      = i_user_rx_valid && !fifo_full;
        drop       = i_user_rx_valid && fifo_full;
        xfer       = tx_valid_q && i_user_tx_ready;
        load       = !tx_valid_q || xfer;
        rd_en      = load && !fifo_empty;

        wr_ptr_d   = wr_en ? wr_ptr_q + LP_AW'(1) : wr_ptr_q;
        rd_ptr_d   = rd_en ? rd_ptr_q + LP_AW'(1) : rd_ptr_q;
        count_d    = count_q + LP_CW'(wr_en) - LP_CW'(rd_en);

        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        if (load) begin
            // An empty FIFO drops valid but keeps the last byte on the data lines.
            tx_valid_d = rd_en;
            if (rd_en) begin
                tx_data_d = load_data;
            end
        end

        overflow_d = overflow_q || drop;
        drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage carries no reset; only the pointers define what is live.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_user_rx_data;
        end
    end

    assign o_user_tx_data  = tx_data_q;
    assign o_user_tx_valid = tx_valid_q;
    assign o_fifo_count    = count_q;
    assign o_overflow      = overflow_q;
    assign o_drop_cnt      = drop_cnt_q;

endmodule

// File: doc/uart_echo_buffer.md
Name: uart_echo_buffer

Overview:
- Sits between the RX and TX user interfaces of uart_drive in the UART top level.
- Captures each received byte (single-cycle valid pulse), buffers it in a FIFO, and re-presents it on the TX valid/ready handshake to produce a buffered echo.
- Absorbs bursts while the transmitter is busy.
- Reports overflow and drop statistics.

Parameters:
- P_DATA_WIDTH, 8: byte width; must match uart_drive P_UART_DATA_WIDTH.
- P_FIFO_DEPTH, 16: FIFO storage entries; must be a power of 2, minimum 2.
- P_CASE_SWAP, 0: 1 = toggle ASCII letter case (0x41-0x5A <-> 0x61-0x7A) on output; 0 = pass through unchanged.

Ports:
- i_clk, input, 1: system clock (50 MHz domain).
- i_rst, input, 1: asynchronous, active-low reset.
- i_user_rx_data, input, P_DATA_WIDTH: received byte from uart_drive.
- i_user_rx_valid, input, 1: one-cycle pulse; i_user_rx_data is valid in that cycle.
- o_user_tx_data, output, P_DATA_WIDTH: byte to uart_drive TX.
- o_user_tx_valid, output, 1: o_user_tx_data is valid.
- i_user_tx_ready, input, 1: uart_drive can accept a byte.
- o_fifo_count, output, log2(P_FIFO_DEPTH)+1: entries in FIFO memory; the output register is excluded.
- o_overflow, output, 1: sticky; set on the first dropped byte.
- o_drop_cnt, output, 16: count of dropped bytes; saturates at 0xFFFF.

Behaviour:
- Reset (i_rst low, asynchronous): pointers = 0, o_fifo_count = 0, o_user_tx_valid = 0, o_user_tx_data = 0, o_overflow = 0, o_drop_cnt = 0. Outputs stay at these values while reset is held.
- Reset mid-operation: buffered bytes and any pending TX byte are discarded. No partial handshake survives reset.
- Write:
  - On a clock edge with i_user_rx_valid = 1 and count < P_FIFO_DEPTH, store the byte at wr_ptr and increment wr_ptr, wrapping modulo P_FIFO_DEPTH.
- Full:
  - If count == P_FIFO_DEPTH at the edge, the byte is dropped, o_overflow is set, and o_drop_cnt increments (saturating).
  - This holds even if a read occurs in the same cycle; the full decision uses pre-edge count.
- Output stage: a single register holding o_user_tx_data and o_user_tx_valid.
  - Handshake: transfer occurs at an edge where o_user_tx_valid = 1 and i_user_tx_ready = 1.
  - While valid and not ready, data and valid hold stable.
  - Valid never deasserts without a transfer.
  - Load condition: (o_user_tx_valid = 0) OR (transfer this edge).
  - If the load condition holds and count > 0: load mem[rd_ptr] (case-swapped if P_CASE_SWAP = 1), increment rd_ptr (wrapping), set valid = 1.
  - If the load condition holds and count == 0: valid = 0; data holds its last value.
- Simultaneous write and read: count is unchanged; both pointers advance.
- Empty-to-output path: the FIFO is not bypassed.
  - Byte written at edge N appears on o_user_tx_valid/o_user_tx_data after edge N+1.
  - Latency is 2 cycles from the rx_valid cycle.
- Back-to-back transfers: with ready held high and the FIFO non-empty, one byte transfers per clock.
- Total buffering capacity is P_FIFO_DEPTH + 1 bytes (memory plus output register).
- o_fifo_count is registered and reflects post-edge state.
- Case swap applies only to bytes 0x41-0x5A and 0x61-0x7A (XOR 0x20). All other values pass unchanged.
- No combinational path from i_user_tx_ready to o_user_tx_valid or o_user_tx_data.

Test Plan:
1. Single byte, ready = 1: rx 0x55 at cycle 10 -> tx_valid = 1 with data 0x55 at cycle 12; transfer completes; tx_valid = 0 at cycle 13; count = 0.
2. Backpressure: ready = 0; rx 0x01, 0x02, 0x03 on separate cycles -> tx_data = 0x01 held stable with valid = 1; count = 2. Raise ready -> 0x01, 0x02, 0x03 transfer on consecutive cycles in order.
3. Overflow (depth 16): ready = 0; send 20 bytes 0x00-0x13 -> output register holds 0x00; FIFO holds 0x01-0x10; 0x11-0x13 are dropped; o_overflow = 1; o_drop_cnt = 3. Drain with ready = 1 -> exactly 0x00-0x10 emitted.
4. Full with simultaneous read: FIFO full, ready = 1 pulse coinciding with rx 0xAA -> 0xAA dropped; o_drop_cnt increments; count = 15.
5. Wrap-around: stream 40 bytes with ready toggling every 3 cycles -> output sequence identical to input sequence (scoreboard); pointers wrap twice; no drops.
6. P_CASE_SWAP = 1: rx 'a' (0x61), 'Z' (0x5A), '5' (0x35) -> tx 0x41, 0x7A, 0x35. Assert i_rst low mid-stream -> all outputs return to zero asynchronously; later traffic resumes correctly.
